// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes and memory-wait freezes.
// Ports: id_*/ex_* hazard sources, branch_taken, mem_busy -> pipeline write enables, flushes, state, stats.
// Optional statistics counters are enabled by defining HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
  parameter int REG_AW            = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        state,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } st_t;

  localparam logic [3:0] LSC_M1 = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FC4    = 4'(FLUSH_CYCLES);

  st_t        st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  assign lu = ex_is_load & ex_rd_we &
              ((id_use_rs1 & (id_rs1 == ex_rd)) |
               (id_use_rs2 & (id_rs2 == ex_rd)));

  assign state = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RUN;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (!mem_busy) begin
      if (branch_taken) begin
        // A redirect aborts any stall and (re)starts the flush window.
        if (FLUSH_CYCLES > 0) begin
          st_d  = FLUSH;
          cnt_d = FC4;
        end else begin
          st_d  = RUN;
          cnt_d = 4'd0;
        end
      end else begin
        unique case (st_q)
          RUN: begin
            if (lu && (LOAD_STALL_CYCLES > 1)) begin
              st_d  = LU_STALL;
              cnt_d = LSC_M1;
            end
          end
          LU_STALL, FLUSH: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) st_d = RUN;
          end
          default: begin
            st_d  = RUN;
            cnt_d = 4'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    exmem_we   = 1'b0;
    memwb_we   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_we = 1'b0;
    end else if (branch_taken) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      unique case (st_q)
        RUN: begin
          pc_we      = ~lu;
          ifid_we    = ~lu;
          idex_flush = lu;
        end
        LU_STALL: begin
          idex_flush = 1'b1;
        end
        FLUSH: begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
        end
        default: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_we && !mem_busy && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (branch_taken && !mem_busy && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 3: register-address width, matching the 8-entry register file.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1: bubble cycles inserted per load-use hazard, legal range 1..15.
REQ-003 Parameter FLUSH_CYCLES, default 0: extra IF/ID flush cycles after a redirect, legal range 0..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 id_rs1, id_rs2  input  REG_AW each  source registers of the instruction in ID.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  the ID instruction reads rs1/rs2.
REQ-008 ex_rd  input  REG_AW  destination register of the instruction in EX.
REQ-009 ex_rd_we, ex_is_load  input  1 each  EX instruction writes rd / is a load.
REQ-010 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-011 mem_busy  input  1  data memory not ready; freeze the whole pipeline.
REQ-012 pc_we, ifid_we, exmem_we, memwb_we  output  1 each  pipeline register write enables.
REQ-013 ifid_flush, idex_flush  output  1 each  load a bubble into IF/ID or ID/EX.
REQ-014 state  output  2  FSM state: RUN=0, LU_STALL=1, FLUSH=2.
REQ-015 stall_cnt, flush_cnt  output  16 each  hazard statistics (see Configuration).

Function
REQ-016 Load-use hazard lu = ex_is_load & ex_rd_we & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); all register addresses are compared, none special.
REQ-017 Outputs are combinational from state, counter and inputs; state and a 4-bit down-counter cnt are registered.
REQ-018 Priority in every state: mem_busy > branch_taken > lu.
REQ-019 mem_busy=1, any state: all write enables 0, both flushes 0; state, cnt and statistics hold.
REQ-020 RUN, no event: all write enables 1, flushes 0, stay RUN.
REQ-021 RUN, lu: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=memwb_we=1; if LOAD_STALL_CYCLES>1, go LU_STALL with cnt=LOAD_STALL_CYCLES-1, else stay RUN.
REQ-022 LU_STALL: same outputs as REQ-021 regardless of lu; cnt decrements; when cnt==1, go RUN.
REQ-023 branch_taken in RUN or LU_STALL: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, exmem_we=memwb_we=1; any stall is aborted; if FLUSH_CYCLES>0, go FLUSH with cnt=FLUSH_CYCLES, else go RUN.
REQ-024 FLUSH: all write enables 1, ifid_flush=1, idex_flush=0; lu is ignored; cnt decrements; when cnt==1, go RUN.
REQ-025 branch_taken in FLUSH: REQ-023 outputs apply and cnt reloads to FLUSH_CYCLES.
REQ-026 ifid_flush and ifid_we may be high together; the flush wins in the IF/ID register.

Reset
REQ-027 rst_n low: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0, asynchronously.
REQ-028 While rst_n is low: all write enables 0, ifid_flush=1, idex_flush=1.
REQ-029 Reset asserted mid-stall or mid-flush abandons the sequence; the first cycle after release behaves as RUN.

Configuration
REQ-030 Macro HAZARD_CTRL_STATS_EN defined: stall_cnt increments on each cycle with pc_we=0 and mem_busy=0; flush_cnt increments on each branch_taken redirect; both saturate at 16'hFFFF.
REQ-031 Macro HAZARD_CTRL_STATS_EN undefined: the statistics ports remain and are tied to 0; no counter logic exists.

Verification
REQ-032 Defaults; ex_is_load=1, ex_rd_we=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> one cycle with pc_we=0, ifid_we=0, idex_flush=1; state stays 0.
REQ-033 LOAD_STALL_CYCLES=3, same hazard -> pc_we=0 for exactly 3 cycles; state sequence 0,1,1,0.
REQ-034 FLUSH_CYCLES=2; branch_taken for 1 cycle -> ifid_flush=1 for 3 cycles, idex_flush=1 in the first cycle only; state sequence 0,2,2,0.
REQ-035 lu and branch_taken together -> redirect outputs (pc_we=1, both flushes 1), no stall; with mem_busy also 1, all enables 0 and no flush.
REQ-036 mem_busy=1 for 4 cycles during LU_STALL (cnt=2) -> cnt and state hold; stall resumes after mem_busy drops and completes with the remaining cycles.
REQ-037 With HAZARD_CTRL_STATS_EN: after 5 load-use stalls and 2 redirects, stall_cnt=5 and flush_cnt=2; pulse rst_n mid-FLUSH -> both counters 0 and state 0.
